// File: rtl/wb_pkg.sv
// Shared definitions for the writeback-port arbiter slice.
//   N_DEF, DEST_W_DEF : default result / destination widths
//   src_t             : which source owns the writeback slot this cycle
//   clog2()           : ceiling log2, used to size counters and pointers
package wb_pkg;

    localparam int unsigned N_DEF      = 8;
    localparam int unsigned DEST_W_DEF = 10;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_CP
    } src_t;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_cp_fifo.sv
// Synchronous FIFO buffering co-processor results (destination + data).
//   clock, reset           : rising-edge clock, async active-high reset
//   push, push_dest/data   : write request; ignored while full
//   pop                    : remove head; ignored while empty
//   head_dest, head_data   : current head entry (valid when !empty)
//   count, full, empty     : registered occupancy status
module wb_cp_fifo
    import wb_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned DEST_W = DEST_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DEST_W-1:0]             push_dest,
    input  logic [N-1:0]                  push_data,
    input  logic                          pop,
    output logic [DEST_W-1:0]             head_dest,
    output logic [N-1:0]                  head_data,
    output logic [clog2(DEPTH+1)-1:0]     count,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned CW = clog2(DEPTH + 1);
    localparam int unsigned PW = clog2(DEPTH);

    logic [DEST_W-1:0] dest_mem [DEPTH];
    logic [N-1:0]      data_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Both qualifiers use the registered count, so a pop never frees a
    // slot for a push in the same cycle.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_dest = dest_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            dest_mem[wr_ptr] <= push_dest;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares one registered writeback port between the EX/MW pipeline and the
// CNN co-processor result stream. Pipeline writes win; co-processor results
// queue in a FIFO and drain into idle slots. A starvation guard stalls the
// pipeline for one cycle once the FIFO has lost STARVE_LIMIT arbitrations.
//   clock, reset                  : rising-edge clock, async active-high reset
//   pipe_wen/pipe_dest/pipe_res   : pipeline write request
//   pipe_stall                    : pipeline must hold its request this cycle
//   cp_valid/cp_dest/cp_data      : co-processor result stream
//   cp_ready                      : FIFO can accept (valid&&ready at edge)
//   wr_en/wr_dest/wr_data         : registered write port
//   cp_pending                    : FIFO occupancy
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned N            = N_DEF,
    parameter int unsigned DEST_W       = DEST_W_DEF,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 7
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          pipe_wen,
    input  logic [DEST_W-1:0]             pipe_dest,
    input  logic [N-1:0]                  pipe_res,
    output logic                          pipe_stall,
    input  logic                          cp_valid,
    input  logic [DEST_W-1:0]             cp_dest,
    input  logic [N-1:0]                  cp_data,
    output logic                          cp_ready,
    output logic                          wr_en,
    output logic [DEST_W-1:0]             wr_dest,
    output logic [N-1:0]                  wr_data,
    output logic [clog2(DEPTH+1)-1:0]     cp_pending
);

    localparam int unsigned CW = clog2(DEPTH + 1);
    localparam int unsigned SW = clog2(STARVE_LIMIT + 1);

    logic [DEST_W-1:0] head_dest;
    logic [N-1:0]      head_data;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic [SW-1:0]     starve_cnt;
    logic              force_cp;
    logic              push;
    logic              pop;
    src_t              src;

    wb_cp_fifo #(
        .N      (N),
        .DEST_W (DEST_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_dest (cp_dest),
        .push_data (cp_data),
        .pop       (pop),
        .head_dest (head_dest),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Gated by reset so the producer sees not-ready throughout reset.
    assign cp_ready   = !full && !reset;
    assign push       = cp_valid && cp_ready;
    assign pop        = (src == SRC_CP);
    assign cp_pending = count;
    assign pipe_stall = force_cp;

    always_comb begin
        src      = SRC_NONE;
        force_cp = !empty && (starve_cnt == SW'(STARVE_LIMIT));
        if (force_cp)      src = SRC_CP;
        else if (pipe_wen) src = SRC_PIPE;
        else if (!empty)   src = SRC_CP;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_dest    <= '0;
            wr_data    <= '0;
            starve_cnt <= '0;
        end else begin
            case (src)
                SRC_PIPE: begin
                    wr_en   <= 1'b1;
                    wr_dest <= pipe_dest;
                    wr_data <= pipe_res;
                end
                SRC_CP: begin
                    wr_en   <= 1'b1;
                    wr_dest <= head_dest;
                    wr_data <= head_data;
                end
                default: begin
                    wr_en   <= 1'b0;
                    wr_dest <= '0;
                    wr_data <= '0;
                end
            endcase

            if (empty || src == SRC_CP)
                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a table of directed single-cycle
// vectors followed by hand-written starvation, full-FIFO and reset sequences.
module tb_wb_port_arbiter;

    logic       clock;
    logic       reset;
    logic       pipe_wen;
    logic [9:0] pipe_dest;
    logic [7:0] pipe_res;
    logic       pipe_stall;
    logic       cp_valid;
    logic [9:0] cp_dest;
    logic [7:0] cp_data;
    logic       cp_ready;
    logic       wr_en;
    logic [9:0] wr_dest;
    logic [7:0] wr_data;
    logic [2:0] cp_pending;

    int n_checks;
    int n_fail;

    wb_port_arbiter #(
        .N            (8),
        .DEST_W       (10),
        .DEPTH        (4),
        .STARVE_LIMIT (7)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pipe_wen   (pipe_wen),
        .pipe_dest  (pipe_dest),
        .pipe_res   (pipe_res),
        .pipe_stall (pipe_stall),
        .cp_valid   (cp_valid),
        .cp_dest    (cp_dest),
        .cp_data    (cp_data),
        .cp_ready   (cp_ready),
        .wr_en      (wr_en),
        .wr_dest    (wr_dest),
        .wr_data    (wr_data),
        .cp_pending (cp_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       pwen;
        logic [9:0] pdest;
        logic [7:0] pres;
        logic       cv;
        logic [9:0] cdest;
        logic [7:0] cdata;
        logic       e_en;
        logic [9:0] e_dest;
        logic [7:0] e_data;
        logic       e_stall;
        logic [2:0] e_pend;
        logic       e_ready;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [9:0] d, input logic [7:0] r);
        chk({tag, ".wr_en"},   32'(wr_en),   32'(en));
        chk({tag, ".wr_dest"}, 32'(wr_dest), 32'(d));
        chk({tag, ".wr_data"}, 32'(wr_data), 32'(r));
    endtask

    task automatic idle_inputs();
        pipe_wen  = 1'b0;
        pipe_dest = '0;
        pipe_res  = '0;
        cp_valid  = 1'b0;
        cp_dest   = '0;
        cp_data   = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        reset = 1'b1;

        // Table: pipeline write, co-processor into idle port (2-cycle
        // latency), then push+pop at count=2 with the pipeline idle.
        //          pwen  pdest   pres   cv    cdest   cdata  en    dest    data   stl   pnd   rdy
        vecs[0]  = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 1'b0, 3'd0, 1'b1};
        vecs[1]  = '{1'b1, 10'h005, 8'hA5, 1'b0, 10'h000, 8'h00, 1'b1, 10'h005, 8'hA5, 1'b0, 3'd0, 1'b1};
        vecs[2]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h200, 8'h3C, 1'b0, 10'h000, 8'h00, 1'b0, 3'd1, 1'b1};
        vecs[3]  = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 1'b1, 10'h200, 8'h3C, 1'b0, 3'd0, 1'b1};
        vecs[4]  = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 1'b0, 3'd0, 1'b1};
        vecs[5]  = '{1'b1, 10'h011, 8'h11, 1'b1, 10'h301, 8'h01, 1'b1, 10'h011, 8'h11, 1'b0, 3'd1, 1'b1};
        vecs[6]  = '{1'b1, 10'h012, 8'h12, 1'b1, 10'h302, 8'h02, 1'b1, 10'h012, 8'h12, 1'b0, 3'd2, 1'b1};
        vecs[7]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h303, 8'h03, 1'b1, 10'h301, 8'h01, 1'b0, 3'd2, 1'b1};
        vecs[8]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h304, 8'h04, 1'b1, 10'h302, 8'h02, 1'b0, 3'd2, 1'b1};
        vecs[9]  = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 1'b1, 10'h303, 8'h03, 1'b0, 3'd1, 1'b1};
        vecs[10] = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 1'b1, 10'h304, 8'h04, 1'b0, 3'd0, 1'b1};
        vecs[11] = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 8'h00, 1'b0, 3'd0, 1'b1};

        // Power-on reset.
        step();
        step();
        chk_wr("por", 1'b0, 10'h000, 8'h00);
        chk("por.pending", 32'(cp_pending), 32'd0);
        chk("por.ready",   32'(cp_ready),   32'd0);
        chk("por.stall",   32'(pipe_stall), 32'd0);
        reset = 1'b0;
        #1;
        chk("por.ready_release", 32'(cp_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            pipe_wen  = vecs[i].pwen;
            pipe_dest = vecs[i].pdest;
            pipe_res  = vecs[i].pres;
            cp_valid  = vecs[i].cv;
            cp_dest   = vecs[i].cdest;
            cp_data   = vecs[i].cdata;
            step();
            chk($sformatf("vec%0d.wr_en", i),   32'(wr_en),      32'(vecs[i].e_en));
            chk($sformatf("vec%0d.wr_dest", i), 32'(wr_dest),    32'(vecs[i].e_dest));
            chk($sformatf("vec%0d.wr_data", i), 32'(wr_data),    32'(vecs[i].e_data));
            chk($sformatf("vec%0d.stall", i),   32'(pipe_stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d.pending", i), 32'(cp_pending), 32'(vecs[i].e_pend));
            chk($sformatf("vec%0d.ready", i),   32'(cp_ready),   32'(vecs[i].e_ready));
        end

        // Starvation: pipeline busy every cycle, one CP entry waiting.
        pipe_wen  = 1'b1;
        pipe_dest = 10'h040;
        pipe_res  = 8'h00;
        cp_valid  = 1'b1;
        cp_dest   = 10'h101;
        cp_data   = 8'h77;
        step();
        cp_valid = 1'b0;
        chk_wr("starve.first", 1'b1, 10'h040, 8'h00);
        chk("starve.pending", 32'(cp_pending), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            pipe_dest = 10'(10'h040 + i);
            pipe_res  = 8'(i);
            chk($sformatf("starve.nostall%0d", i), 32'(pipe_stall), 32'd0);
            step();
            chk_wr($sformatf("starve.pipe%0d", i), 1'b1, 10'(10'h040 + i), 8'(i));
        end
        pipe_dest = 10'h048;
        pipe_res  = 8'h08;
        chk("starve.stall", 32'(pipe_stall), 32'd1);
        step();
        chk_wr("starve.forced", 1'b1, 10'h101, 8'h77);
        chk("starve.pending0", 32'(cp_pending), 32'd0);
        chk("starve.unstall",  32'(pipe_stall), 32'd0);
        step();
        chk_wr("starve.held", 1'b1, 10'h048, 8'h08);
        idle_inputs();
        step();
        chk_wr("starve.idle", 1'b0, 10'h000, 8'h00);

        // Full FIFO: fill with the pipeline winning, reject a 5th push
        // (also while a pop happens), then drain in push order.
        pipe_wen = 1'b1;
        cp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pipe_dest = 10'(10'h050 + i);
            pipe_res  = 8'(8'h50 + i);
            cp_dest   = 10'(10'h2E0 + i);
            cp_data   = 8'(8'hE0 + i);
            step();
            chk_wr($sformatf("full.pipe%0d", i), 1'b1, 10'(10'h050 + i), 8'(8'h50 + i));
        end
        chk("full.pending4", 32'(cp_pending), 32'd4);
        chk("full.ready0",   32'(cp_ready),   32'd0);
        pipe_dest = 10'h054;
        pipe_res  = 8'h54;
        cp_dest   = 10'h3FF;
        cp_data   = 8'hFF;
        step();
        chk_wr("full.pipe4", 1'b1, 10'h054, 8'h54);
        chk("full.reject", 32'(cp_pending), 32'd4);
        pipe_wen = 1'b0;
        step();
        cp_valid = 1'b0;
        chk_wr("full.drain0", 1'b1, 10'h2E0, 8'hE0);
        chk("full.popnopush", 32'(cp_pending), 32'd3);
        for (int i = 1; i < 4; i++) begin
            step();
            chk_wr($sformatf("full.drain%0d", i), 1'b1, 10'(10'h2E0 + i), 8'(8'hE0 + i));
        end
        chk("full.empty", 32'(cp_pending), 32'd0);
        step();
        chk_wr("full.nodup", 1'b0, 10'h000, 8'h00);

        // Reset mid-stream with three entries buffered.
        pipe_wen = 1'b1;
        cp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pipe_dest = 10'(10'h060 + i);
            pipe_res  = 8'(8'h60 + i);
            cp_dest   = 10'(10'h2A0 + i);
            cp_data   = 8'(8'hA0 + i);
            step();
        end
        chk("rst.pending3", 32'(cp_pending), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk_wr("rst.async", 1'b0, 10'h000, 8'h00);
        chk("rst.pending", 32'(cp_pending), 32'd0);
        chk("rst.ready",   32'(cp_ready),   32'd0);
        step();
        chk_wr("rst.held", 1'b0, 10'h000, 8'h00);
        chk("rst.ready_held", 32'(cp_ready), 32'd0);
        #2;
        idle_inputs();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_wr($sformatf("rst.after%0d", i), 1'b0, 10'h000, 8'h00);
            chk($sformatf("rst.after_pend%0d", i),  32'(cp_pending), 32'd0);
            chk($sformatf("rst.after_ready%0d", i), 32'(cp_ready),   32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single writeback port (result + 10-bit destination + write enable) between the RISC-V EX/MW pipeline and the CNN co-processor result stream.
- Pipeline writes have priority. Co-processor results are buffered in a small FIFO and drain into idle slots.
- A starvation guard stalls the pipeline for one cycle to force a co-processor write.
- Sits between the EX/MW pipeline register / CNN co-processor and the register-file/memory write port.

Parameters:
- N, 8: result data width.
- DEST_W, 10: destination address width.
- DEPTH, 4: co-processor FIFO depth, power of 2, at least 2.
- STARVE_LIMIT, 7: maximum consecutive cycles a non-empty FIFO may lose arbitration; at least 1.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pipe_wen  in  1  pipeline write request.
- pipe_dest  in  DEST_W  pipeline destination.
- pipe_res  in  N  pipeline result.
- pipe_stall  out  1  pipeline must hold pipe_* this cycle; its write is not taken.
- cp_valid  in  1  co-processor result valid.
- cp_dest  in  DEST_W  co-processor destination.
- cp_data  in  N  co-processor result.
- cp_ready  out  1  FIFO can accept; transfer occurs when cp_valid and cp_ready are both high at a rising edge.
- wr_en  out  1  registered write enable to the write port.
- wr_dest  out  DEST_W  registered write destination.
- wr_data  out  N  registered write data.
- cp_pending  out  clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, active-high):
  - wr_en, wr_dest, wr_data, pipe_stall = 0.
  - FIFO emptied; cp_pending = 0; starve_cnt = 0.
  - cp_ready forced 0 while reset is high.
  - Reset mid-operation discards buffered entries and any in-flight write. No partial write is emitted after release.
- Arbitration (combinational each cycle from the registered count, starve_cnt and pipe_wen):
  - force = (count != 0) && (starve_cnt == STARVE_LIMIT).
  - force: grant the co-processor (pop FIFO head); pipe_stall = 1, independent of pipe_wen.
  - else pipe_wen = 1: grant the pipeline; pipe_stall = 0.
  - else count != 0: grant the co-processor (pop).
  - else: no grant.
- Output register:
  - On each rising edge, wr_en <= granted; wr_dest/wr_data <= the winner's values.
  - With no grant: wr_en <= 0, wr_dest <= 0, wr_data <= 0.
  - Pipeline latency is 1 cycle.
- FIFO:
  - cp_ready = !full, registered-count based, so no combinational path from pop.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle (not full, not empty): count unchanged, order preserved.
  - A push into an empty FIFO is not poppable until the next cycle. Minimum co-processor latency, accept to wr_en, is 2 cycles.
  - Pointers wrap modulo DEPTH.
- starve_cnt:
  - Cleared when count == 0 or the co-processor is granted.
  - Otherwise +1 per cycle with count != 0 and the pipeline granted or no grant; saturates at STARVE_LIMIT.
- Pipeline handshake: while pipe_stall = 1, the pipeline holds pipe_wen/pipe_dest/pipe_res. The held write wins on the next cycle, since starve_cnt has cleared.
- No write is ever duplicated or dropped, except through reset.

Decomposition:
- wb_pkg holds:
  - DEST_W default;
  - N default;
  - grant-source enum {SRC_NONE, SRC_PIPE, SRC_CP};
  - the clog2 helper.
- Sub-module wb_cp_fifo: synchronous FIFO with parameters N, DEST_W, DEPTH.
  - Outputs: head data/dest, count, full, empty.
  - Inputs: push, pop.
- Arbitration, starve counter and output register stay in wb_port_arbiter.

Test Plan:
1. Reset: hold 3 entries pending, assert reset mid-stream -> wr_en=0, cp_pending=0 and cp_ready=0 while reset is high; cp_ready=1 and no writes emitted after release.
2. Pipeline only: pipe_wen=1, dest=0x005, res=0xA5 sampled at edge k -> after edge k, wr_en=1, wr_dest=0x005, wr_data=0xA5; pipe_stall stays 0.
3. Co-processor into an idle port: push dest=0x200, data=0x3C at edge k -> after edge k+1, wr_en=1, wr_dest=0x200, wr_data=0x3C; cp_pending returns to 0.
4. Starvation: pipe_wen=1 every cycle, one CP entry (dest=0x101) -> pipeline wins 7 cycles; 8th cycle pipe_stall=1 and 0x101 written; the held pipeline write follows next cycle.
5. Full: with pipe_wen=1 and starve_cnt < 7, push 4 entries -> cp_pending=4 and cp_ready=0; a 5th cp_valid is not accepted; the entries drain in push order.
6. Simultaneous push and pop at count=2 with the pipeline idle -> count stays 2; the output order matches push order.
